// File: rtl/exec_unit_if.sv
// Request / write-back bundle between the register file and the execute stage.
// The bench drives the request side as master; exec_unit is the slave.
interface exec_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_data0;
  logic [DATA_WIDTH-1:0] i_data1;
  logic [ADDR_WIDTH-1:0] i_dst;
  logic                  o_busy;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  o_zero;
  logic                  o_carry;

  modport master (
    output i_start, i_op, i_data0, i_data1, i_dst,
    input  o_busy, o_wr_en, o_wr_addr, o_wr_data, o_zero, o_carry
  );

  modport slave (
    input  i_start, i_op, i_data0, i_data1, i_dst,
    output o_busy, o_wr_en, o_wr_addr, o_wr_data, o_zero, o_carry
  );
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute stage behind the register file. Single-cycle ALU ops
// finish one edge after start; MUL runs a DATA_WIDTH-step shift-add loop.
// The result is written back as a one-cycle pulse; register 0 is never written.
module exec_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input logic        i_CLK,
  input logic        i_RSTn,
  exec_unit_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;       // also the MUL multiplier, shifted right per step
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [2*DATA_WIDTH-1:0] mcand_q;   // multiplicand, shifted left per step
  logic [2*DATA_WIDTH-1:0] acc_q;     // partial product
  logic [CNT_W-1:0]        cnt_q;

  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    zero_q;
  logic                    carry_q;

  logic load, step, finish;

  logic [DATA_WIDTH:0]     alu_wide;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_c;
  logic [2*DATA_WIDTH-1:0] prod_next;

  // Next partial product; on the last MUL step this is the full product.
  always_comb begin
    prod_next = acc_q + (b_q[0] ? mcand_q : '0);
  end

  // Result and carry/borrow/overflow for the latched op.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_res  = alu_wide[DATA_WIDTH-1:0];
        alu_c    = alu_wide[DATA_WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (A < B unsigned).
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = alu_wide[DATA_WIDTH-1:0];
        alu_c    = alu_wide[DATA_WIDTH];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = a_q << 1;
        alu_c   = a_q[DATA_WIDTH-1];
      end
      OP_SHR: begin
        alu_res = a_q >> 1;
        alu_c   = a_q[0];
      end
      OP_MUL: begin
        alu_res = prod_next[DATA_WIDTH-1:0];
        alu_c   = |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  // Control state register.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (op_q != OP_MUL || cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          state_d = S_WB;
        end else begin
          step = 1'b1;
        end
      end
      S_WB:    state_d = S_IDLE;   // a start seen on this edge is dropped
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch and shift-add iteration.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      op_q    <= bus.i_op;
      a_q     <= bus.i_data0;
      b_q     <= bus.i_data1;
      dst_q   <= bus.i_dst;
      mcand_q <= {{DATA_WIDTH{1'b0}}, bus.i_data0};
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (step) begin
      acc_q   <= prod_next;
      mcand_q <= mcand_q << 1;
      b_q     <= b_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Write-back port and flags, loaded on WB entry; port idles at zero.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      if (finish && dst_q != '0) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= dst_q;
        wr_data_q <= alu_res;
      end else begin
        wr_en_q   <= 1'b0;
        wr_addr_q <= '0;
        wr_data_q <= '0;
      end
      if (finish) begin
        zero_q  <= (alu_res == '0);
        carry_q <= alu_c;
      end
    end
  end

  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_zero    = zero_q;
  assign bus.o_carry   = carry_q;

endmodule
